// File: rtl/player_motion_ctl_pkg.sv
// Screen geometry and walk-state encoding shared by the player motion controllers.
package player_motion_ctl_pkg;

  localparam int SCREEN_W = 1024;
  localparam int SPRITE_W = 64;
  localparam int SPRITE_H = 64;
  localparam int POS_W    = 12;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t WALK_L = 2'd1;
  localparam state_t WALK_R = 2'd2;

endpackage

// File: rtl/player_motion_ctl_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous button input.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/player_motion_ctl.sv
// Per-frame sprite position and leg-animation control, advanced once per vsync rising edge.
// state  | meaning
// IDLE   | no walk, xpos holds, legs image shown
// WALK_L | moving left by STEP each frame, clamped at X_MIN
// WALK_R | moving right by STEP each frame, clamped at X_MAX
module player_motion_ctl
  import player_motion_ctl_pkg::*;
#(
  parameter int X_INIT   = 75,
  parameter int Y_INIT   = 600,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = SCREEN_W - SPRITE_W,
  parameter int STEP     = 4,
  parameter int ANIM_DIV = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left,
  input  logic             right,
  input  logic             vsync_in,
  output logic [POS_W-1:0] xpos,
  output logic [POS_W-1:0] ypos,
  output logic             legs_sel,
  output logic             facing_left,
  output logic             moving,
  output logic             frame_tick
);

  localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [POS_W-1:0] X_INIT_P = POS_W'(X_INIT);
  localparam logic [POS_W-1:0] X_MIN_P  = POS_W'(X_MIN);
  localparam logic [POS_W-1:0] X_MAX_P  = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] STEP_P   = POS_W'(STEP);
  localparam logic [POS_W-1:0] L_THRESH = POS_W'(X_MIN + STEP);
  localparam logic [POS_W-1:0] R_THRESH = POS_W'(X_MAX - STEP);
  localparam logic [CW-1:0]    CNT_LAST = CW'(ANIM_DIV - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

  logic l_s, r_s;
  logic vsync_q, arm_q, frame_tick_q, tick;
  state_t state_q, state_d;
  logic [POS_W-1:0] xpos_q, xpos_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic legs_q, legs_d, facing_q, facing_d;

  sync_2ff u_sync_left  (.clk(clk), .reset(reset), .d_i(left),  .q_o(l_s));
  sync_2ff u_sync_right (.clk(clk), .reset(reset), .d_i(right), .q_o(r_s));

  // arm_q blocks a tick right after reset until vsync has been seen low.
  assign tick = vsync_in & ~vsync_q & arm_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      if (l_s && !r_s)      state_d = WALK_L;
      else if (r_s && !l_s) state_d = WALK_R;
      else                  state_d = IDLE;
    end
  end

  always_comb begin
    moving = (state_q != IDLE);
  end

  // Entering a walk state counts as the first animation frame of that walk.
  always_comb begin
    xpos_d   = xpos_q;
    cnt_d    = cnt_q;
    legs_d   = legs_q;
    facing_d = facing_q;
    if (tick) begin
      case (state_d)
        WALK_L: begin
          xpos_d   = (xpos_q < L_THRESH) ? X_MIN_P : xpos_q - STEP_P;
          facing_d = 1'b1;
        end
        WALK_R: begin
          xpos_d   = (xpos_q > R_THRESH) ? X_MAX_P : xpos_q + STEP_P;
          facing_d = 1'b0;
        end
        default: ;
      endcase
      if (state_d == IDLE) begin
        cnt_d  = '0;
        legs_d = 1'b0;
      end else if (state_d != state_q) begin
        cnt_d  = CNT_ONE;
        legs_d = 1'b0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        legs_d = ~legs_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q      <= 1'b0;
      arm_q        <= 1'b0;
      frame_tick_q <= 1'b0;
      xpos_q       <= X_INIT_P;
      cnt_q        <= '0;
      legs_q       <= 1'b0;
      facing_q     <= 1'b0;
    end else begin
      vsync_q      <= vsync_in;
      arm_q        <= arm_q | ~vsync_in;
      frame_tick_q <= tick;
      xpos_q       <= xpos_d;
      cnt_q        <= cnt_d;
      legs_q       <= legs_d;
      facing_q     <= facing_d;
    end
  end

  assign xpos        = xpos_q;
  assign ypos        = POS_W'(Y_INIT);
  assign legs_sel    = legs_q;
  assign facing_left = facing_q;
  assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_player_motion_ctl.sv
// Scoreboard bench: a frame-level player model predicts each frame's outputs, a monitor checks them on frame_tick.
module tb_player_motion_ctl;

  localparam int XI = 75, YI = 600, XMIN = 0, XMAX = 960, STP = 4, ADIV = 8;

  logic clk = 1'b0;
  logic reset, left, right, vsync_in;
  logic [11:0] xpos, ypos;
  logic legs_sel, facing_left, moving, frame_tick;

  always #5 clk = ~clk;

  player_motion_ctl dut (
    .clk(clk), .reset(reset), .left(left), .right(right), .vsync_in(vsync_in),
    .xpos(xpos), .ypos(ypos), .legs_sel(legs_sel), .facing_left(facing_left),
    .moving(moving), .frame_tick(frame_tick)
  );

  typedef struct {
    int x;
    bit mv;
    bit fl;
    bit lg;
  } exp_t;

  exp_t sb[$];
  int n_total = 0;
  int n_pass  = 0;

  int mx, mdir, mrun;
  bit mface;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    mx = XI; mdir = 0; mrun = 0; mface = 1'b0;
    sb.delete();
  endtask

  // One frame of player behaviour: direction from buttons, clamped step, run length drives legs.
  task automatic model_frame(input bit l, input bit r);
    exp_t e;
    int d;
    d = (l && !r) ? -1 : ((r && !l) ? 1 : 0);
    if (d == 0) mrun = 0;
    else if (d == mdir) mrun++;
    else mrun = 1;
    mdir = d;
    if (d < 0) begin
      mface = 1'b1;
      mx = (mx - STP < XMIN) ? XMIN : mx - STP;
    end else if (d > 0) begin
      mface = 1'b0;
      mx = (mx + STP > XMAX) ? XMAX : mx + STP;
    end
    e.x  = mx;
    e.mv = (d != 0);
    e.fl = mface;
    e.lg = ((mrun / ADIV) % 2) == 1;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && frame_tick) begin
      if (sb.size() == 0) begin
        check("frame_tick_unexpected", frame_tick, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("xpos", xpos, e.x);
        check("ypos", ypos, YI);
        check("moving", moving, e.mv);
        check("facing_left", facing_left, e.fl);
        check("legs_sel", legs_sel, e.lg);
      end
    end
  end

  task automatic do_frame(input bit l, input bit r);
    @(negedge clk);
    left = l; right = r;
    repeat (4) @(negedge clk);
    model_frame(l, r);
    vsync_in = 1'b1;
    repeat (10) @(negedge clk);
    vsync_in = 1'b0;
    repeat (10) @(negedge clk);
    check("frame_seen", sb.size(), 0);
    sb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; left = 1'b0; right = 1'b0; vsync_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; left = 1'b0; right = 1'b0; vsync_in = 1'b0;
    model_reset();

    // reset with vsync toggling, released while vsync is high
    @(negedge clk); vsync_in = 1'b1;
    @(negedge clk); check("reset_tick0", frame_tick, 0); vsync_in = 1'b0;
    @(negedge clk); check("reset_tick1", frame_tick, 0); vsync_in = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_xpos", xpos, XI);
    check("rst_ypos", ypos, YI);
    check("rst_legs", legs_sel, 0);
    check("rst_moving", moving, 0);
    check("rst_facing", facing_left, 0);
    repeat (3) begin
      @(negedge clk);
      check("no_stale_tick", frame_tick, 0);
    end
    vsync_in = 1'b0;
    repeat (3) @(negedge clk);

    // walk right three frames
    for (int i = 0; i < 3; i++) do_frame(1'b0, 1'b1);
    check("walk_right_x", xpos, 87);

    // left clamp from reset
    do_reset();
    for (int i = 0; i < 20; i++) do_frame(1'b1, 1'b0);
    check("clamp_left_x", xpos, 0);
    check("clamp_left_moving", moving, 1);

    // both buttons
    for (int i = 0; i < 4; i++) do_frame(1'b1, 1'b1);
    check("both_idle", moving, 0);

    // walk right to 200, then reset mid-walk
    for (int i = 0; i < 50; i++) do_frame(1'b0, 1'b1);
    check("reach_200", xpos, 200);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("midwalk_rst_x", xpos, XI);
    check("midwalk_rst_moving", moving, 0);
    reset = 1'b0;
    model_reset();
    right = 1'b0;
    @(negedge clk);

    // animation: 16 frames right then release
    for (int i = 0; i < 16; i++) do_frame(1'b0, 1'b1);
    do_frame(1'b0, 1'b0);

    // button pulse entirely between vsync edges
    @(negedge clk); right = 1'b1;
    repeat (100) @(negedge clk);
    right = 1'b0;
    repeat (5) @(negedge clk);
    check("midframe_x", xpos, mx);
    check("midframe_moving", moving, 0);
    do_frame(1'b0, 1'b0);

    // randomized runs of button patterns
    for (int k = 0; k < 30; k++) begin
      int pat, len;
      pat = $urandom_range(0, 3);
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) do_frame(pat[0], pat[1]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
